im_loader: RTL and testbench

- Write-side counterpart to the instruction memory read port. Accepts a byte stream from the UART receiver, packs the bytes into 16-bit instruction words, and writes them sequentially into instruction memory starting at address 0.
- Holds the CPU off the memory while loading, so a program can be downloaded without resynthesis.
- Sits between the UART RX block and the instruction memory's write port.

---
 rtl/im_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_im_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Packs a UART byte stream (SYNC, LEN_H, LEN_L, word pairs) into 16-bit instruction memory writes.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module im_loader #(
   parameter int ADDR_W = 16,
   parameter int MAX_WORDS = 2048,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdy,
   output logic              clr_rx_rdy,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_H,
      S_LEN_L,
      S_DATA_H,
      S_DATA_L,
      S_WR,
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_FIN,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              clr_q, clr_d;
   logic              held_q, held_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        hi_q, hi_d;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   logic              accept;
   logic              consume;
   logic [15:0]       new_len;
   logic [15:0]       cnt_inc;

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      held_d  = held_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      new_len = {len_q[15:8], rx_data};
      cnt_inc = cnt_q + 16'd1;

      accept = (state_q == S_IDLE) || (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
               (state_q == S_DATA_H) || (state_q == S_DATA_L);
`ifdef IM_LOADER_CHECKSUM_EN
      accept = accept || (state_q == S_CHK);
`endif
      // held_q blocks a byte the sender keeps presenting after it was already taken
      consume = rx_rdy && !clr_q && !held_q && accept;
      clr_d   = consume;
      if (consume) begin
         held_d = 1'b1;
      end else if (!rx_rdy) begin
         held_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (consume && (rx_data == SYNC_BYTE)) begin
               state_d = S_LEN_H;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               addr_d  = '0;
               cnt_d   = '0;
`ifdef IM_LOADER_CHECKSUM_EN
               chk_d   = '0;
`endif
            end
         end
         S_LEN_H: begin
            if (consume) begin
               len_d[15:8] = rx_data;
               state_d     = S_LEN_L;
            end
         end
         S_LEN_L: begin
            if (consume) begin
               len_d = new_len;
               if ({1'b0, new_len} > MAX_LEN) begin
                  state_d = S_ERR;
               end else if (new_len == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_FIN;
`endif
               end else begin
                  state_d = S_DATA_H;
               end
            end
         end
         S_DATA_H: begin
            if (consume) begin
               hi_d    = rx_data;
`ifdef IM_LOADER_CHECKSUM_EN
               chk_d   = chk_q ^ rx_data;
`endif
               state_d = S_DATA_L;
            end
         end
         S_DATA_L: begin
            if (consume) begin
               we_d    = 1'b1;
               wdata_d = {hi_q, rx_data};
`ifdef IM_LOADER_CHECKSUM_EN
               chk_d   = chk_q ^ rx_data;
`endif
               state_d = S_WR;
            end
         end
         // Write strobe is high in this state; advance the index once it has been seen
         S_WR: begin
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = cnt_inc;
            if (cnt_inc == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_FIN;
`endif
            end else begin
               state_d = S_DATA_H;
            end
         end
`ifdef IM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (consume) begin
               state_d = (rx_data == chk_q) ? S_FIN : S_ERR;
            end
         end
`endif
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ERR: begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         clr_q   <= 1'b0;
         held_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         held_q  <= held_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
`ifdef IM_LOADER_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

   assign clr_rx_rdy = clr_q;
   assign im_we      = we_q;
   assign im_addr    = addr_q;
   assign im_wdata   = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: framing, length error, held rx_rdy, reset and checksum.
module tb_im_loader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        clr_rx_rdy;
   logic        im_we;
   logic [15:0] im_addr;
   logic [15:0] im_wdata;
   logic        busy;
   logic        done;
   logic        err;

   int assertCount = 0;
   int failCount = 0;

   int wrCount = 0;
   int clrCount = 0;
   int weViol = 0;
   logic prevWe = 1'b0;
   logic [15:0] wrAddr [0:15];
   logic [15:0] wrData [0:15];
   int base;
   int baseClr;

   im_loader dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_rdy(rx_rdy),
      .clr_rx_rdy(clr_rx_rdy),
      .im_we(im_we),
      .im_addr(im_addr),
      .im_wdata(im_wdata),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive monitor recording every memory write and acknowledge pulse
   always @(posedge clk) begin
      prevWe <= im_we;
      if (im_we && prevWe) weViol <= weViol + 1;
      if (clr_rx_rdy) clrCount <= clrCount + 1;
      if (im_we) begin
         wrAddr[wrCount[3:0]] <= im_addr;
         wrData[wrCount[3:0]] <= im_wdata;
         wrCount <= wrCount + 1;
      end
   end

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte and wait (bounded) for its acknowledge pulse
   task automatic applyStimulus(input logic [7:0] b);
      bit got;
      got = 0;
      @(negedge clk);
      rx_data = b;
      rx_rdy = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (clr_rx_rdy) got = 1;
      end
      rx_rdy = 1'b0;
      checkOutput("byteAck", {31'd0, got}, 32'd1);
   endtask

   // Trailing checksum byte only exists when the feature is built in
   task automatic sendChk(input logic [7:0] b);
`ifdef IM_LOADER_CHECKSUM_EN
      applyStimulus(b);
`else
      if (b === 8'hxx) $display("[TB] unreachable");
`endif
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      rx_rdy = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstErr", {31'd0, err}, 32'd0);
      checkOutput("rstWe", {31'd0, im_we}, 32'd0);
      checkOutput("rstAddr", {16'd0, im_addr}, 32'd0);
      checkOutput("rstClr", {31'd0, clr_rx_rdy}, 32'd0);
      rst_n = 1'b1;

      // Reset in the middle of a frame, then a single-word frame
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      checkOutput("midBusy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstAddr", {16'd0, im_addr}, 32'd0);
      checkOutput("midRstWdata", {16'd0, im_wdata}, 32'd0);
      checkOutput("midRstDone", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = wrCount;
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      sendChk(8'h26);
      settle();
      checkOutput("t1Writes", wrCount - base, 32'd1);
      checkOutput("t1Addr", {16'd0, wrAddr[base[3:0]]}, 32'd0);
      checkOutput("t1Data", {16'd0, wrData[base[3:0]]}, 32'h1234);
      checkOutput("t1Done", {31'd0, done}, 32'd1);
      checkOutput("t1Busy", {31'd0, busy}, 32'd0);

      // Leading junk ignored, two-word frame
      base = wrCount;
      applyStimulus(8'h00);
      applyStimulus(8'h7F);
      checkOutput("t2Idle", {31'd0, busy}, 32'd0);
      applyStimulus(8'hA5);
      checkOutput("t2SyncBusy", {31'd0, busy}, 32'd1);
      checkOutput("t2SyncDone", {31'd0, done}, 32'd0);
      applyStimulus(8'h00);
      applyStimulus(8'h02);
      applyStimulus(8'hDE);
      applyStimulus(8'hAD);
      applyStimulus(8'hBE);
      checkOutput("t2MidBusy", {31'd0, busy}, 32'd1);
      applyStimulus(8'hEF);
      sendChk(8'h22);
      settle();
      checkOutput("t2Writes", wrCount - base, 32'd2);
      checkOutput("t2Addr0", {16'd0, wrAddr[base[3:0]]}, 32'd0);
      checkOutput("t2Data0", {16'd0, wrData[base[3:0]]}, 32'hDEAD);
      checkOutput("t2Addr1", {16'd0, wrAddr[4'(base + 1)]}, 32'd1);
      checkOutput("t2Data1", {16'd0, wrData[4'(base + 1)]}, 32'hBEEF);
      checkOutput("t2Done", {31'd0, done}, 32'd1);
      checkOutput("t2Busy", {31'd0, busy}, 32'd0);
      checkOutput("t2AddrEnd", {16'd0, im_addr}, 32'd2);

      // Oversized length aborts; zero-length frame then clears the error
      base = wrCount;
      applyStimulus(8'hA5);
      applyStimulus(8'h08);
      applyStimulus(8'h01);
      settle();
      checkOutput("t3Err", {31'd0, err}, 32'd1);
      checkOutput("t3Done", {31'd0, done}, 32'd0);
      checkOutput("t3Busy", {31'd0, busy}, 32'd0);
      checkOutput("t3Writes", wrCount - base, 32'd0);
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      sendChk(8'h00);
      settle();
      checkOutput("t3ZeroErr", {31'd0, err}, 32'd0);
      checkOutput("t3ZeroDone", {31'd0, done}, 32'd1);
      checkOutput("t3ZeroAddr", {16'd0, im_addr}, 32'd0);
      checkOutput("t3ZeroWrites", wrCount - base, 32'd0);

      // Sync byte held on rx_rdy for four cycles must be taken once
      base = wrCount;
      baseClr = clrCount;
      @(negedge clk);
      rx_data = 8'hA5;
      rx_rdy = 1'b1;
      repeat (4) @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
      checkOutput("t4ClrPulses", clrCount - baseClr, 32'd1);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      sendChk(8'h26);
      settle();
      checkOutput("t4Writes", wrCount - base, 32'd1);
      checkOutput("t4Data", {16'd0, wrData[base[3:0]]}, 32'h1234);
      checkOutput("t4Done", {31'd0, done}, 32'd1);
      checkOutput("t4Err", {31'd0, err}, 32'd0);

`ifdef IM_LOADER_CHECKSUM_EN
      // Bad checksum: the word is written but the load is flagged
      base = wrCount;
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      applyStimulus(8'h27);
      settle();
      checkOutput("t5Err", {31'd0, err}, 32'd1);
      checkOutput("t5Done", {31'd0, done}, 32'd0);
      checkOutput("t5Writes", wrCount - base, 32'd1);
      checkOutput("t5Data", {16'd0, wrData[base[3:0]]}, 32'h1234);
`endif

      checkOutput("weBackToBack", weViol, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
